// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel array sequencer.
package pixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  // Binary to reflected Gray code; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/ramp_gen.sv
// ADC conversion counter with a Gray-coded copy registered alongside it,
// so the pixel bus only ever sees one bit toggle per clock.
module ramp_gen import pixel_pkg::*; #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  output logic [COUNTER_WIDTH-1:0] count_bin,
  output logic [COUNTER_WIDTH-1:0] code_gray
);

  logic [COUNTER_WIDTH-1:0] cnt_nx;

  assign cnt_nx = count_bin + 1'b1;

  // Clear wins over enable so the code is already zero the cycle the ramp stops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_bin <= '0;
      code_gray <= '0;
    end else if (clear) begin
      count_bin <= '0;
      code_gray <= '0;
    end else if (enable) begin
      count_bin <= cnt_nx;
      code_gray <= COUNTER_WIDTH'(bin2gray(32'(cnt_nx)));
    end
  end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a pixel array: erase, expose, single-slope convert,
// then read each pixel out over a valid/ready stream.
module pixel_array_ctrl import pixel_pkg::*; #(
  parameter int PIXEL_COUNT   = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int ERASE_CYCLES  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           abort,
  input  logic [15:0]                    exposure_cycles,
  output logic                           erase,
  output logic                           corr,
  output logic                           expose,
  output logic                           convert,
  output logic                           read,
  output logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  output logic [COUNTER_WIDTH-1:0]       ramp_code,
  input  logic [COUNTER_WIDTH-1:0]       data_in,
  output logic [COUNTER_WIDTH-1:0]       out_data,
  output logic [$clog2(PIXEL_COUNT)-1:0] out_pixel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int PSW  = $clog2(PIXEL_COUNT);
  localparam int PH_W = (COUNTER_WIDTH > 16) ? COUNTER_WIDTH : 16;

  localparam logic [PSW-1:0]  LAST_IDX   = PSW'(PIXEL_COUNT - 1);
  localparam logic [PH_W-1:0] ERASE_LOAD = PH_W'(ERASE_CYCLES - 1);
  localparam logic [PH_W-1:0] CONV_LOAD  = PH_W'((64'd1 << COUNTER_WIDTH) - 64'd1);

  state_t                   state, state_nx;
  logic [PH_W-1:0]          phase_cnt, phase_load;
  logic                     phase_zero;
  logic [15:0]              exp_len;
  logic [PSW-1:0]           idx;
  logic [COUNTER_WIDTH-1:0] conv_count;
  logic                     capture, drain_go, frame_start, restart;
  logic                     ramp_en, ramp_clear;

  assign phase_zero  = (phase_cnt == '0);
  // A new pixel may be taken whenever the output slot is empty or draining.
  assign capture     = (state == S_READ)  && (!out_valid || out_ready) && !abort;
  assign drain_go    = (state == S_DRAIN) && (!out_valid || out_ready) && !abort;
  assign frame_start = (state == S_IDLE)  && start && !abort;
  assign restart     = drain_go && continuous;
  assign ramp_en     = (state == S_CONVERT);
  // Clearing on the next state keeps ramp_code at zero from the first
  // non-convert cycle, including after an abort.
  assign ramp_clear  = (state_nx != S_CONVERT);
  assign pixel_select = idx;

  ramp_gen #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_ramp (
    .clk       (clk),
    .reset     (reset),
    .enable    (ramp_en),
    .clear     (ramp_clear),
    .count_bin (conv_count),
    .code_gray (ramp_code)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nx = S_ERASE;
        S_ERASE:   if (phase_zero) state_nx = S_EXPOSE;
        // Phase timer and ramp counter move in lockstep; both at end of scale.
        S_EXPOSE:  if (phase_zero) state_nx = S_CONVERT;
        S_CONVERT: if (phase_zero && (&conv_count)) state_nx = S_READ;
        S_READ:    if (capture && (idx == LAST_IDX)) state_nx = S_DRAIN;
        S_DRAIN:   if (drain_go) state_nx = continuous ? S_ERASE : S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // Strobes decoded from the current state; corr marks the last erase cycle.
  always_comb begin
    erase      = 1'b0;
    corr       = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    read       = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_ERASE:   begin erase = 1'b1; corr = phase_zero; end
      S_EXPOSE:  expose  = 1'b1;
      S_CONVERT: convert = 1'b1;
      S_READ:    read    = 1'b1;
      S_DRAIN:   frame_done = drain_go;
      default:   ;
    endcase
  end

  // Length of the phase being entered, minus one.
  always_comb begin
    case (state_nx)
      S_ERASE:   phase_load = ERASE_LOAD;
      S_EXPOSE:  phase_load = PH_W'(exp_len - 16'd1);
      S_CONVERT: phase_load = CONV_LOAD;
      default:   phase_load = '0;
    endcase
  end

  // Shared phase down-counter, reloaded on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  phase_cnt <= '0;
    else if (state_nx != state)  phase_cnt <= phase_load;
    else if (!phase_zero)        phase_cnt <= phase_cnt - 1'b1;
  end

  // Exposure length captured at frame start (a zero request still exposes one cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      exp_len <= 16'd1;
    else if (frame_start || restart)
      exp_len <= (exposure_cycles == 16'd0) ? 16'd1 : exposure_cycles;
  end

  // Pixel index: advances only on capture, so a stalled stream stalls the scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       idx <= '0;
    else if (abort)   idx <= '0;
    else if (capture) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
  end

  // Output slot: held while valid and not ready, emptied on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      out_data  <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= data_in;
      out_pixel <= idx;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: scoreboard on the pixel stream plus
// per-frame phase timing checks.
module tb_pixel_array_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, continuous, abort, out_ready;
  logic [15:0] exposure_cycles;
  logic        erase, corr, expose, convert, read, busy, frame_done, out_valid;
  logic [1:0]  pixel_select, out_pixel;
  logic [7:0]  ramp_code, data_in, out_data;
  logic [7:0]  pix_mem [4];

  assign data_in = pix_mem[pixel_select];

  always #5 clk = ~clk;

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .exposure_cycles(exposure_cycles),
    .erase(erase), .corr(corr), .expose(expose), .convert(convert), .read(read),
    .pixel_select(pixel_select), .ramp_code(ramp_code), .data_in(data_in),
    .out_data(out_data), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  logic [9:0] sb [$];
  logic [9:0] m_exp;
  int n_pass = 0, n_tot = 0, m_pass = 0, m_tot = 0;

  // Stream monitor: every accepted beat must match the oldest expected pixel.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      m_tot++;
      if (sb.size() == 0) begin
        $display("FAIL stream_extra: got pixel %0d data %h, expected no beat", out_pixel, out_data);
      end else begin
        m_exp = sb.pop_front();
        if ({out_pixel, out_data} === m_exp) m_pass++;
        else $display("FAIL stream: got pixel %0d data %h, expected pixel %0d data %h",
                      out_pixel, out_data, m_exp[9:8], m_exp[7:0]);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_frame();
    for (int i = 0; i < 4; i++) sb.push_back({2'(i), pix_mem[i]});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Per-frame statistics, filled by collect().
  int         c_cyc, c_erase, c_corr, c_corr_idx, c_expose, c_convert, c_read;
  int         c_overlap, c_ramp_err, c_ramp_out, c_first_erase;
  logic [7:0] c_prev, c_ramp_last;
  logic [39:0] c_head;
  bit         c_done;

  // Sample one frame from the first cycle after start until frame_done.
  task automatic collect(input int budget, input bit poke_start);
    logic [7:0] k;
    c_cyc = 0; c_erase = 0; c_corr = 0; c_corr_idx = -1; c_expose = 0;
    c_convert = 0; c_read = 0; c_overlap = 0; c_ramp_err = 0; c_ramp_out = 0;
    c_first_erase = -1; c_prev = '0; c_ramp_last = '0; c_head = '0; c_done = 0;
    while (!c_done && c_cyc < budget) begin
      @(negedge clk);
      c_cyc++;
      if (poke_start) start = expose && (c_expose == 0);
      if (erase) begin
        if (c_first_erase < 0) c_first_erase = c_cyc;
        if (corr) c_corr_idx = c_erase;
        c_erase++;
      end
      if (corr) c_corr++;
      if (expose) c_expose++;
      if (convert) begin
        k = 8'(c_convert);
        if (ramp_code !== (k ^ (k >> 1))) c_ramp_err++;
        if (c_convert > 0 && $countones(ramp_code ^ c_prev) != 1) c_ramp_err++;
        if (c_convert < 5) c_head = {c_head[31:0], ramp_code};
        c_prev = ramp_code;
        c_ramp_last = ramp_code;
        c_convert++;
      end else if (ramp_code !== 8'h00) begin
        c_ramp_out++;
      end
      if (read) c_read++;
      if (int'(erase) + int'(expose) + int'(convert) + int'(read) > 1) c_overlap++;
      if (frame_done) c_done = 1;
    end
    if (poke_start) start = 1'b0;
    check("frame_done_seen", 64'(c_done), 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    out_ready = 1'b1; exposure_cycles = 16'd3;
    pix_mem = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state
    #12;
    @(negedge clk);
    check("reset_outputs", {erase, corr, expose, convert, read, ramp_code, pixel_select,
                            out_data, out_pixel, out_valid, busy, frame_done}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Basic frame, exposure 3, always ready
    push_frame();
    pulse_start();
    collect(400, 0);
    check("f1_first_erase", 64'(c_first_erase), 64'd1);
    check("f1_erase_len",   64'(c_erase), 64'd4);
    check("f1_corr_pos",    64'(c_corr_idx), 64'd3);
    check("f1_corr_cnt",    64'(c_corr), 64'd1);
    check("f1_expose_len",  64'(c_expose), 64'd3);
    check("f1_convert_len", 64'(c_convert), 64'd256);
    check("f1_ramp_gray",   64'(c_ramp_err), 64'd0);
    check("f1_ramp_head",   64'(c_head), 64'h00_01_03_02_06);
    check("f1_ramp_last",   64'(c_ramp_last), 64'h80);
    check("f1_ramp_idle",   64'(c_ramp_out), 64'd0);
    check("f1_read_len",    64'(c_read), 64'd4);
    check("f1_overlap",     64'(c_overlap), 64'd0);
    check("f1_cycles",      64'(c_cyc), 64'd268);
    @(negedge clk);
    check("f1_end_idle", {busy, frame_done}, 64'd0);
    check("f1_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure: hold out_ready low for 10 cycles in READ
    pix_mem = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    push_frame();
    pulse_start();
    n = 0;
    while (!convert && n < 100) begin @(negedge clk); n++; end
    check("f2_reach_convert", 64'(convert), 64'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    n = 0;
    while (!read && n < 400) begin @(negedge clk); n++; end
    check("f2_reach_read", 64'(read), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("f2_stall", {read, out_valid, out_pixel, pixel_select, out_data},
            {1'b1, 1'b1, 2'd0, 2'd1, 8'h5A});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    while (!frame_done && n < 50) begin @(negedge clk); n++; end
    check("f2_frame_done", 64'(frame_done), 64'd1);
    @(negedge clk);
    check("f2_sb_empty", 64'(sb.size()), 64'd0);
    check("f2_end_idle", 64'(busy), 64'd0);

    // Continuous mode with zero exposure request
    exposure_cycles = 16'd0; continuous = 1'b1;
    pix_mem = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_frame();
    pulse_start();
    collect(400, 0);
    check("f3_expose_len", 64'(c_expose), 64'd1);
    check("f3_cycles",     64'(c_cyc), 64'd266);
    @(posedge clk); #1 continuous = 1'b0;
    pix_mem = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    push_frame();
    collect(400, 0);
    check("f3b_first_erase", 64'(c_first_erase), 64'd1);
    check("f3b_erase_len",   64'(c_erase), 64'd4);
    check("f3b_expose_len",  64'(c_expose), 64'd1);
    @(negedge clk);
    check("f3_end_idle", 64'(busy), 64'd0);
    check("f3_sb_empty", 64'(sb.size()), 64'd0);

    // Abort in the middle of CONVERT
    exposure_cycles = 16'd3;
    pulse_start();
    n = 0;
    while (!convert && n < 100) begin @(negedge clk); n++; end
    check("ab_reach_convert", 64'(convert), 64'd1);
    repeat (20) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("ab_outputs", {erase, corr, expose, convert, read, ramp_code, pixel_select,
                         out_data, out_pixel, out_valid, busy, frame_done}, 64'd0);
    pix_mem = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_frame();
    pulse_start();
    collect(400, 0);
    check("ab_restart_cycles", 64'(c_cyc), 64'd268);
    @(negedge clk);
    check("ab_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of EXPOSE
    pulse_start();
    n = 0;
    while (!expose && n < 20) begin @(negedge clk); n++; end
    check("rs_reach_expose", 64'(expose), 64'd1);
    reset = 1'b0;
    #1;
    check("rs_outputs", {erase, corr, expose, convert, read, ramp_code, pixel_select,
                         out_data, out_pixel, out_valid, busy, frame_done}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rs_waits_idle", 64'(busy), 64'd0);
    pix_mem = '{8'h99, 8'h88, 8'h77, 8'h66};
    push_frame();
    pulse_start();
    collect(400, 0);
    check("rs_restart_cycles", 64'(c_cyc), 64'd268);
    @(negedge clk);
    check("rs_sb_empty", 64'(sb.size()), 64'd0);

    // start pulsed during EXPOSE must not disturb the frame
    exposure_cycles = 16'd5;
    pix_mem = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_frame();
    pulse_start();
    collect(400, 1);
    check("ig_erase_len",   64'(c_erase), 64'd4);
    check("ig_expose_len",  64'(c_expose), 64'd5);
    check("ig_convert_len", 64'(c_convert), 64'd256);
    check("ig_cycles",      64'(c_cyc), 64'd270);
    @(negedge clk);
    check("ig_end_idle", 64'(busy), 64'd0);
    check("ig_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass + m_pass, n_tot + m_tot);
    $finish;
  end

endmodule

// File: doc/pixel_array_ctrl.md
PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_COUNT, default 4, number of pixels sequenced (>=2).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 8, ADC ramp/code width.
REQ-003 SHALL have parameter ERASE_CYCLES, default 4, erase phase length (>=1).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-007 SHALL have port continuous  input  1  1 = restart a frame automatically after each frame; sampled at frame end.
REQ-008 SHALL have port abort  input  1  forces return to IDLE.
REQ-009 SHALL have port exposure_cycles  input  16  expose phase length; sampled at start.
REQ-010 SHALL have port erase, corr, expose, convert, read  output  1 each  pixel control strobes.
REQ-011 SHALL have port pixel_select  output  $clog2(PIXEL_COUNT)  pixel addressed during read.
REQ-012 SHALL have port ramp_code  output  COUNTER_WIDTH  Gray-coded conversion count driven to the pixel bus.
REQ-013 SHALL have port data_in  input  COUNTER_WIDTH  latched code from the selected pixel.
REQ-014 SHALL have port out_data, out_pixel, out_valid, out_ready  output/output/output/input  COUNTER_WIDTH/$clog2(PIXEL_COUNT)/1/1  pixel stream.
REQ-015 SHALL have port busy, frame_done  output  1 each  frame in progress; one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ, DRAIN.
REQ-017 IDLE->ERASE on start; start in any other state SHALL be ignored.
REQ-018 ERASE SHALL last ERASE_CYCLES cycles with erase=1; corr=1 only in its last cycle.
REQ-019 EXPOSE SHALL last max(exposure_cycles,1) cycles with expose=1.
REQ-020 CONVERT SHALL last 2^COUNTER_WIDTH cycles with convert=1; binary counter runs 0..2^W-1; ramp_code = count ^ (count>>1), registered with the count.
REQ-021 ramp_code SHALL be 0 outside CONVERT.
REQ-022 READ SHALL assert read=1, pixel_select=idx, with idx starting at 0.
REQ-023 In READ, when out_valid=0 or out_ready=1, SHALL capture data_in into out_data, idx into out_pixel, set out_valid=1, then increment idx.
REQ-024 After capturing pixel PIXEL_COUNT-1, SHALL go to DRAIN with read=0.
REQ-025 out_valid SHALL clear on out_valid&out_ready with no new capture; out_data/out_pixel SHALL be stable while out_valid&!out_ready.
REQ-026 DRAIN SHALL wait until out_valid=0 or out_ready=1, then pulse frame_done for one cycle and go to ERASE if continuous=1, else IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort SHALL take priority over all transitions: next state IDLE, all strobes 0, idx 0, out_valid 0; no frame_done.
REQ-029 At most one of erase, expose, convert, read SHALL be high in any cycle.

Reset
REQ-030 On reset low, SHALL immediately enter IDLE with all strobes 0, ramp_code 0, pixel_select 0, out_data 0, out_pixel 0, out_valid 0, busy 0, frame_done 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for a new start.

Structure
REQ-032 State enum and Gray-conversion function SHALL reside in shared package pixel_pkg.
REQ-033 The conversion counter plus Gray encoding SHALL be one sub-module, ramp_gen (parameter COUNTER_WIDTH; enable, clear, count_bin, code_gray).
REQ-034 Phase timing SHALL use one shared down-counter reloaded on each state entry.

Verification
REQ-035 Defaults, exposure_cycles=3, out_ready=1, start pulse -> erase 4 cycles (corr in 4th), expose 3, convert 256, 4 outputs with pixels 0..3, frame_done 1 cycle, IDLE.
REQ-036 During CONVERT, ramp_code sequence SHALL be 0,1,3,2,6,... with exactly one bit change per cycle; final value 0x80.
REQ-037 out_ready=0 for 10 cycles during READ -> out_data held stable, idx stalls; no pixel lost or duplicated.
REQ-038 continuous=1 -> a second ERASE begins the cycle after frame_done; exposure_cycles=0 -> 1-cycle expose.
REQ-039 abort mid-CONVERT, and separately reset low mid-EXPOSE -> IDLE next edge / immediately, all outputs 0, start accepted afterwards.
REQ-040 start pulsed during EXPOSE -> ignored; frame timing unchanged.
